// File: rtl/cpu_pkg.sv
// Shared types and ISA field positions for the multicycle 16-bit-ISA CPU.
// Opcodes, R-type function codes and FSM states are defined here.
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_RTYPE = 3'b000,
      OP_LW    = 3'b001,
      OP_SW    = 3'b010,
      OP_BEQ   = 3'b011,
      OP_ADDI  = 3'b100,
      OP_J     = 3'b101,
      OP_BNE   = 3'b110,
      OP_HALT  = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      F_ADD  = 3'b000,
      F_SUB  = 3'b001,
      F_AND  = 3'b010,
      F_OR   = 3'b011,
      F_SLT  = 3'b100,
      F_NOP5 = 3'b101,
      F_NOP6 = 3'b110,
      F_NOP7 = 3'b111
   } funct_t;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEM, WB, HALT
   } state_t;

   localparam int REG_ADDR_W = 3;
   localparam int OP_LSB     = 13;
   localparam int RS_LSB     = 10;
   localparam int RT_LSB     = 7;
   localparam int RD_LSB     = 4;
   localparam int IMM_W      = 7;
   localparam int JADDR_W    = 13;

   // Function codes 101..111 retire without touching the register file.
   function automatic logic functWrites(input funct_t f);
      return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
   endfunction

endpackage

// File: rtl/regfile.sv
// Eight-entry register file: two asynchronous read ports, one synchronous write
// port; r0 always reads zero and ignores writes.
module regfile
   import cpu_pkg::*;
#(
   parameter int n = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] i_rs,
   input  logic [REG_ADDR_W-1:0] i_rt,
   output logic [n-1:0]          o_rsData,
   output logic [n-1:0]          o_rtData,
   input  logic                  i_we,
   input  logic [REG_ADDR_W-1:0] i_wAddr,
   input  logic [n-1:0]          i_wData
);

   logic [n-1:0] r_regs [8];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_wAddr != '0)) begin
         r_regs[i_wAddr] <= i_wData;
      end
   end

   assign o_rsData = (i_rs == '0) ? '0 : r_regs[i_rs];
   assign o_rtData = (i_rt == '0) ? '0 : r_regs[i_rt];

endmodule

// File: rtl/cpu_multicycle.sv
// Multicycle CPU with a single shared req/ready memory port; tolerates any
// number of memory wait states and reports retirement and halt.
module cpu_multicycle
   import cpu_pkg::*;
#(
   parameter int           n        = 16,
   parameter logic [n-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset,
   output logic         mem_req,
   output logic         mem_we,
   output logic [n-1:0] mem_addr,
   output logic [n-1:0] mem_wdata,
   input  logic         mem_ready,
   input  logic [n-1:0] mem_rdata,
   output logic [n-1:0] pc,
   output logic         retire,
   output logic         halted
);

   state_t       r_state;
   logic [n-1:0] r_pc, r_a, r_b, r_imm, r_aluOut, r_mdr;
   logic [15:0]  r_ir;
   logic         r_memReq, r_memWe, r_halted;
   logic [n-1:0] r_memAddr, r_memWdata;

   opcode_t      w_op;
   funct_t       w_funct;
   logic [n-1:0] w_rsData, w_rtData, w_sext, w_aluB, w_aluResult;
   logic [n-1:0] w_jumpPc, w_branchPc, w_wbData;
   logic         w_branchTaken, w_memDone, w_wbEn;
   logic [REG_ADDR_W-1:0] w_wbAddr;

   assign w_op      = opcode_t'(r_ir[15:OP_LSB]);
   assign w_funct   = funct_t'(r_ir[2:0]);
   assign w_sext    = {{(n-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
   assign w_jumpPc  = {r_pc[n-1:JADDR_W], r_ir[JADDR_W-1:0]};
   assign w_memDone = r_memReq && mem_ready;
   assign w_aluB    = (w_op == OP_RTYPE) ? r_b : r_imm;

   assign w_branchTaken = ((w_op == OP_BEQ) && (r_a == r_b)) || ((w_op == OP_BNE) && (r_a != r_b));
   assign w_branchPc    = w_branchTaken ? (r_pc + r_imm) : r_pc;

   assign w_wbEn   = (r_state == WB) &&
                     ((w_op == OP_RTYPE) ? functWrites(w_funct) : ((w_op == OP_ADDI) || (w_op == OP_LW)));
   assign w_wbAddr = (w_op == OP_RTYPE) ? r_ir[RD_LSB +: REG_ADDR_W] : r_ir[RT_LSB +: REG_ADDR_W];
   assign w_wbData = (w_op == OP_LW) ? r_mdr : r_aluOut;

   regfile #(.n(n)) u_regfile (
      .clk      (clk),
      .reset    (reset),
      .i_rs     (r_ir[RS_LSB +: REG_ADDR_W]),
      .i_rt     (r_ir[RT_LSB +: REG_ADDR_W]),
      .o_rsData (w_rsData),
      .o_rtData (w_rtData),
      .i_we     (w_wbEn),
      .i_wAddr  (w_wbAddr),
      .i_wData  (w_wbData)
   );

   always_comb begin
      w_aluResult = r_a + w_aluB;
      if (w_op == OP_RTYPE) begin
         case (w_funct)
            F_SUB:   w_aluResult = r_a - r_b;
            F_AND:   w_aluResult = r_a & r_b;
            F_OR:    w_aluResult = r_a | r_b;
            F_SLT: begin
               w_aluResult    = '0;
               w_aluResult[0] = $signed(r_a) < $signed(r_b);
            end
            default: w_aluResult = r_a + r_b;
         endcase
      end
   end

   // Retire flags the last cycle of each instruction, so it is decoded from the current state.
   always_comb begin
      retire = 1'b0;
      case (r_state)
         DECODE:  retire = (w_op == OP_J);
         EXEC:    retire = (w_op == OP_BEQ) || (w_op == OP_BNE);
         MEM:     retire = w_memDone && (w_op == OP_SW);
         WB:      retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= FETCH;
         r_pc        <= RESET_PC;
         r_ir        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_imm       <= '0;
         r_aluOut    <= '0;
         r_mdr       <= '0;
         r_memReq    <= 1'b0;
         r_memWe     <= 1'b0;
         r_memAddr   <= '0;
         r_memWdata  <= '0;
         r_halted    <= 1'b0;
      end else begin
         case (r_state)
            // Leaving reset, FETCH first raises the request; afterwards it arrives with req already up.
            FETCH: begin
               if (!r_memReq) begin
                  r_memReq  <= 1'b1;
                  r_memWe   <= 1'b0;
                  r_memAddr <= r_pc;
               end else if (mem_ready) begin
                  r_ir     <= mem_rdata[15:0];
                  r_pc     <= r_pc + 1'b1;
                  r_memReq <= 1'b0;
                  r_state  <= DECODE;
               end
            end
            DECODE: begin
               r_a   <= w_rsData;
               r_b   <= w_rtData;
               r_imm <= w_sext;
               case (w_op)
                  OP_J: begin
                     r_pc      <= w_jumpPc;
                     r_memReq  <= 1'b1;
                     r_memWe   <= 1'b0;
                     r_memAddr <= w_jumpPc;
                     r_state   <= FETCH;
                  end
                  OP_HALT: begin
                     r_halted <= 1'b1;
                     r_state  <= HALT;
                  end
                  default: r_state <= EXEC;
               endcase
            end
            EXEC: begin
               r_aluOut <= w_aluResult;
               case (w_op)
                  OP_BEQ, OP_BNE: begin
                     r_pc      <= w_branchPc;
                     r_memReq  <= 1'b1;
                     r_memWe   <= 1'b0;
                     r_memAddr <= w_branchPc;
                     r_state   <= FETCH;
                  end
                  OP_LW, OP_SW: begin
                     r_memReq   <= 1'b1;
                     r_memWe    <= (w_op == OP_SW);
                     r_memAddr  <= w_aluResult;
                     r_memWdata <= r_b;
                     r_state    <= MEM;
                  end
                  default: r_state <= WB;
               endcase
            end
            MEM: begin
               if (mem_ready) begin
                  r_memWe <= 1'b0;
                  if (w_op == OP_SW) begin
                     r_memAddr <= r_pc;
                     r_state   <= FETCH;
                  end else begin
                     r_mdr    <= mem_rdata;
                     r_memReq <= 1'b0;
                     r_state  <= WB;
                  end
               end
            end
            WB: begin
               r_memReq  <= 1'b1;
               r_memWe   <= 1'b0;
               r_memAddr <= r_pc;
               r_state   <= FETCH;
            end
            HALT:    r_state <= HALT;
            default: r_state <= FETCH;
         endcase
      end
   end

   assign mem_req   = r_memReq;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;
   assign pc        = r_pc;
   assign halted    = r_halted;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: a 16-bit core on a wait-state memory model
// and a 32-bit core on a zero-wait memory, checked against hand-computed values.
module tb_cpu_multicycle;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 16-bit core with a configurable-latency memory
   logic        resetA;
   logic        reqA, weA, readyA, retireA, haltedA;
   logic [15:0] addrA, wdataA, rdataA, pcA;
   logic [15:0] memA [64];
   int          waitA = 0;
   int          cntA = 0;
   logic        pokeEnA = 1'b0;
   int          pokeAddrA = 0;
   logic [15:0] pokeDataA = '0;

   // 32-bit core with an always-ready memory
   logic        resetB;
   logic        reqB, weB, readyB, retireB, haltedB;
   logic [31:0] addrB, wdataB, rdataB, pcB;
   logic [31:0] memB [64];
   logic        pokeEnB = 1'b0;
   int          pokeAddrB = 0;
   logic [31:0] pokeDataB = '0;
   int          outOfRangeB = 0;

   int   cycA = 0;
   int   retireCntA = 0;
   int   retireCyc [64];
   int   firstReqCyc = -1;
   logic monEn = 1'b0;
   logic pendA = 1'b0;
   logic [15:0] prevAddr = '0, prevWdata = '0;
   logic prevWe = 1'b0;
   int   stabErr = 0;
   int   stabSamples = 0;

   cpu_multicycle #(.n(16), .RESET_PC(16'd0)) dutA (
      .clk(clk), .reset(resetA), .mem_req(reqA), .mem_we(weA), .mem_addr(addrA),
      .mem_wdata(wdataA), .mem_ready(readyA), .mem_rdata(rdataA), .pc(pcA),
      .retire(retireA), .halted(haltedA)
   );

   cpu_multicycle #(.n(32), .RESET_PC(32'd0)) dutB (
      .clk(clk), .reset(resetB), .mem_req(reqB), .mem_we(weB), .mem_addr(addrB),
      .mem_wdata(wdataB), .mem_ready(readyB), .mem_rdata(rdataB), .pc(pcB),
      .retire(retireB), .halted(haltedB)
   );

   assign readyA = reqA && (cntA >= waitA);
   assign rdataA = memA[addrA[5:0]];
   assign readyB = reqB;
   assign rdataB = memB[addrB[5:0]];

   // Memory A: bench pokes plus DUT writes on completion; cntA counts wait cycles
   always @(posedge clk) begin
      if (pokeEnA) memA[pokeAddrA] <= pokeDataA;
      if (reqA && readyA && weA) memA[addrA[5:0]] <= wdataA;
      if (!reqA || readyA) cntA <= 0;
      else cntA <= cntA + 1;
   end

   always @(posedge clk) begin
      if (pokeEnB) memB[pokeAddrB] <= pokeDataB;
      if (reqB && weB) memB[addrB[5:0]] <= wdataB;
      if (reqB && (addrB >= 32'd64)) outOfRangeB <= outOfRangeB + 1;
   end

   // Cycle, retire and first-request bookkeeping for core A
   always @(negedge clk) begin
      cycA <= cycA + 1;
      if (retireA) begin
         if (retireCntA < 64) retireCyc[retireCntA] <= cycA;
         retireCntA <= retireCntA + 1;
      end
      if (reqA && (firstReqCyc < 0)) firstReqCyc <= cycA;
   end

   // A request still waiting at an edge must present identical fields next cycle
   always @(posedge clk) begin
      pendA     <= reqA && !readyA;
      prevAddr  <= addrA;
      prevWe    <= weA;
      prevWdata <= wdataA;
   end

   always @(negedge clk) begin
      if (monEn && pendA) begin
         stabSamples <= stabSamples + 1;
         if (!reqA || (addrA != prevAddr) || (weA != prevWe) || (wdataA != prevWdata))
            stabErr <= stabErr + 1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic pokeA(input int a, input logic [15:0] d);
      pokeEnA = 1'b1; pokeAddrA = a; pokeDataA = d;
      @(posedge clk); #1;
      pokeEnA = 1'b0;
   endtask

   task automatic pokeB(input int a, input logic [31:0] d);
      pokeEnB = 1'b1; pokeAddrB = a; pokeDataB = d;
      @(posedge clk); #1;
      pokeEnB = 1'b0;
   endtask

   task automatic waitRetires(input int target, input int budget);
      int i = 0;
      while ((retireCntA < target) && (i < budget)) begin
         @(posedge clk); #1;
         i++;
      end
      if (retireCntA < target) checkOutput("retireTimeout", 32'(retireCntA), 32'(target));
   endtask

   task automatic waitHaltA(input int budget);
      int i = 0;
      while (!haltedA && (i < budget)) begin
         @(posedge clk); #1;
         i++;
      end
      checkOutput("haltedA", 32'(haltedA), 32'd1);
   endtask

   function automatic logic [15:0] encI(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt, input logic [6:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [15:0] encR(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd, input logic [2:0] f);
      return {3'b000, rs, rt, rd, 1'b0, f};
   endfunction

   function automatic logic [15:0] encJ(input logic [12:0] addr);
      return {3'b101, addr};
   endfunction

   task automatic applyStimulus();
      for (int i = 0; i < 64; i++) begin
         pokeA(i, 16'h0);
         pokeB(i, 32'h0);
      end
      pokeA(0,  encI(3'b100, 3'd0, 3'd1, 7'd5));
      pokeA(1,  encI(3'b100, 3'd0, 3'd2, 7'h7D));
      pokeA(2,  encR(3'd1, 3'd2, 3'd3, 3'd0));
      pokeA(3,  encJ(13'd20));
      pokeA(20, encI(3'b010, 3'd0, 3'd3, 7'd4));
      pokeA(21, encI(3'b001, 3'd0, 3'd4, 7'd4));
      pokeA(22, encI(3'b010, 3'd0, 3'd4, 7'd5));
      pokeA(23, encJ(13'd10));
      pokeA(10, encI(3'b011, 3'd1, 3'd1, 7'h7F));
      pokeA(11, encI(3'b100, 3'd0, 3'd0, 7'd7));
      pokeA(12, encI(3'b010, 3'd0, 3'd0, 7'd6));
      pokeA(13, 16'hE000);
      pokeB(0,  32'(encI(3'b100, 3'd0, 3'd5, 7'h7F)));
      pokeB(1,  32'(encR(3'd5, 3'd5, 3'd6, 3'd0)));
      pokeB(2,  32'(encR(3'd5, 3'd0, 3'd7, 3'd4)));
      pokeB(3,  32'(encR(3'd5, 3'd6, 3'd1, 3'd2)));
      pokeB(4,  32'(encR(3'd7, 3'd6, 3'd2, 3'd3)));
      pokeB(5,  32'(encR(3'd7, 3'd5, 3'd3, 3'd1)));
      pokeB(6,  32'(encR(3'd5, 3'd5, 3'd7, 3'd5)));
      pokeB(7,  32'(encI(3'b010, 3'd0, 3'd6, 7'd40)));
      pokeB(8,  32'(encI(3'b010, 3'd0, 3'd7, 7'd41)));
      pokeB(9,  32'(encI(3'b010, 3'd0, 3'd1, 7'd42)));
      pokeB(10, 32'(encI(3'b010, 3'd0, 3'd2, 7'd43)));
      pokeB(11, 32'(encI(3'b010, 3'd0, 3'd3, 7'd44)));
      pokeB(12, 32'h0000_E000);
   endtask

   initial begin
      int reqSeen;
      int i;
      resetA = 1'b1;
      resetB = 1'b1;
      applyStimulus();

      checkOutput("rstPc", 32'(pcA), 32'd0);
      checkOutput("rstReq", 32'(reqA), 32'd0);
      checkOutput("rstWe", 32'(weA), 32'd0);
      checkOutput("rstRetire", 32'(retireA), 32'd0);
      checkOutput("rstHalted", 32'(haltedA), 32'd0);

      // addi, addi, add with zero-wait memory
      resetA = 1'b0;
      monEn  = 1'b1;
      waitRetires(3, 100);
      checkOutput("t1Cycles", 32'(retireCyc[2] - firstReqCyc + 1), 32'd12);
      checkOutput("t1Cpi", 32'(retireCyc[1] - retireCyc[0]), 32'd4);

      // store/load with three wait cycles per access
      waitA = 3;
      waitRetires(7, 400);
      checkOutput("t2Mem4", 32'(memA[4]), 32'd2);
      checkOutput("t2LwR4", 32'(memA[5]), 32'd2);
      checkOutput("t2LwCycles", 32'(retireCyc[5] - retireCyc[4]), 32'd11);

      // taken beq loops to itself; swap in a not-taken bne to escape
      waitRetires(9, 200);
      checkOutput("t3BeqPc", 32'(pcA), 32'd10);
      pokeA(10, encI(3'b110, 3'd1, 3'd1, 7'h7F));
      waitRetires(10, 200);
      checkOutput("t3BnePc", 32'(pcA), 32'd11);

      waitHaltA(300);
      checkOutput("t6HaltPc", 32'(pcA), 32'd14);
      checkOutput("t6R0Zero", 32'(memA[6]), 32'd0);
      checkOutput("t6Retires", 32'(retireCntA), 32'd12);
      reqSeen = 0;
      for (i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (reqA) reqSeen++;
      end
      checkOutput("t6NoReq", 32'(reqSeen), 32'd0);
      checkOutput("t6NoRetire", 32'(retireCntA), 32'd12);
      checkOutput("t6Sticky", 32'(haltedA), 32'd1);
      checkOutput("t2Stable", 32'(stabErr), 32'd0);
      checkOutput("t2WaitSeen", 32'(stabSamples > 0), 32'd1);

      // async reset while a store waits in MEM
      monEn  = 1'b0;
      resetA = 1'b1;
      @(posedge clk); #1;
      resetA = 1'b0;
      i = 0;
      while (!(reqA && weA) && (i < 300)) begin
         @(posedge clk); #1;
         i++;
      end
      checkOutput("t5InMem", 32'(reqA && weA), 32'd1);
      resetA = 1'b1;
      #1;
      checkOutput("t5ReqDrop", 32'(reqA), 32'd0);
      checkOutput("t5Pc", 32'(pcA), 32'd0);
      checkOutput("t5Retire", 32'(retireA), 32'd0);
      pokeA(0, encI(3'b010, 3'd0, 3'd3, 7'd7));
      pokeA(1, 16'hE000);
      pokeA(7, 16'hDEAD);
      resetA = 1'b0;
      waitHaltA(300);
      checkOutput("t5RegsCleared", 32'(memA[7]), 32'd0);
      checkOutput("t5HaltPc", 32'(pcA), 32'd2);

      // 32-bit datapath
      resetB = 1'b0;
      i = 0;
      while (!haltedB && (i < 400)) begin
         @(posedge clk); #1;
         i++;
      end
      checkOutput("t4HaltedB", 32'(haltedB), 32'd1);
      checkOutput("t4AddR6", memB[40], 32'hFFFF_FFFE);
      checkOutput("t4SltR7", memB[41], 32'd1);
      checkOutput("t4AndR1", memB[42], 32'hFFFF_FFFE);
      checkOutput("t4OrR2", memB[43], 32'hFFFF_FFFF);
      checkOutput("t4SubR3", memB[44], 32'd2);
      checkOutput("t4PcB", pcB, 32'd13);
      checkOutput("t4AddrRange", 32'(outOfRangeB), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
